tile_order_reader: RTL and testbench

Consumer end of the tile-order interface. Captures a packed picture order (one 6-bit picture ID per board slot, 24 slots), checks that it is a permutation of 0..23, then streams the slots out one at a time over a valid/ready handshake to the board display/game logic. A malformed order is flagged and never streamed.

---
 rtl/tile_order_reader_if.sv | 28 ++
 rtl/tile_order_reader.sv | 139 +++++++++++++
 tb/tb_tile_order_reader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tile_order_reader_if.sv
// Tile-order handshake bundle: order load strobe/data in, per-slot tile stream out.
// master = order source / tile sink, slave = tile_order_reader.
interface tile_order_reader_if #(
  parameter int N_TILES = 24,
  parameter int ID_W    = 6,
  parameter int POS_W   = 5
);
  logic                      load;
  logic [N_TILES*ID_W-1:0]   order_in;
  logic                      busy;
  logic                      error;
  logic                      tile_valid;
  logic                      tile_ready;
  logic [POS_W-1:0]          tile_pos;
  logic [ID_W-1:0]           tile_id;
  logic                      tile_last;
  logic                      done;

  modport master (
    output load, order_in, tile_ready,
    input  busy, error, tile_valid, tile_pos, tile_id, tile_last, done
  );

  modport slave (
    input  load, order_in, tile_ready,
    output busy, error, tile_valid, tile_pos, tile_id, tile_last, done
  );
endinterface

// File: rtl/tile_order_reader.sv
// Captures a packed picture order, verifies it is a permutation one slot/cycle (N_TILES cycles),
// then streams slots over valid/ready; outputs hold while tile_ready is low, load ignored while busy.
module tile_order_reader #(
  parameter int N_TILES = 24,
  parameter int ID_W    = 6,
  parameter int POS_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  tile_order_reader_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  localparam int               ORD_W    = N_TILES * ID_W;
  localparam int               N_SLOTS  = 2 ** POS_W;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_TILES - 1);
  localparam logic [ID_W:0]    ID_LIM   = (ID_W + 1)'(N_TILES);

  logic             rst_meta_q;
  logic             rst_sync_q;

  logic [1:0]       state_q, state_d;
  logic [ORD_W-1:0] order_q, order_d;
  logic [N_TILES-1:0] seen_q, seen_d;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [ID_W-1:0]  slot_a [N_SLOTS];
  logic [ID_W-1:0]  cur_id;
  logic             id_in_range;
  logic             id_seen;
  logic             slot_bad;
  logic             at_last;
  logic             streaming;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Slot 0 sits in the MSBs; unused tail entries read as zero.
  always_comb begin
    for (int k = 0; k < N_SLOTS; k++) begin
      slot_a[k] = '0;
    end
    for (int k = 0; k < N_TILES; k++) begin
      slot_a[k] = order_q[(N_TILES-1-k)*ID_W +: ID_W];
    end
  end

  assign cur_id      = slot_a[cnt_q];
  assign id_in_range = ({1'b0, cur_id} < ID_LIM);
  assign id_seen     = id_in_range && seen_q[cur_id[POS_W-1:0]];
  assign slot_bad    = !id_in_range || id_seen;
  assign at_last     = (cnt_q == LAST_POS);
  assign streaming   = (state_q == ST_STREAM);

  always_comb begin
    state_d = state_q;
    order_d = order_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (bus.load) begin
          order_d = bus.order_in;
          seen_d  = '0;
          cnt_d   = '0;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (slot_bad) begin
          state_d = ST_ERROR;
        end else begin
          seen_d[cur_id[POS_W-1:0]] = 1'b1;
          if (at_last) begin
            cnt_d   = '0;
            state_d = ST_STREAM;
          end else begin
            cnt_d = cnt_q + POS_W'(1);
          end
        end
      end

      ST_STREAM: begin
        if (bus.tile_ready) begin
          if (at_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + POS_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= ST_IDLE;
      order_q <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Tile fields are forced to zero whenever no tile is being offered.
  assign bus.busy       = (state_q == ST_CHECK) || streaming;
  assign bus.error      = (state_q == ST_ERROR);
  assign bus.tile_valid = streaming;
  assign bus.tile_pos   = streaming ? cnt_q : '0;
  assign bus.tile_id    = streaming ? cur_id : '0;
  assign bus.tile_last  = streaming && at_last;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_tile_order_reader.sv
// Randomized bench for tile_order_reader against a slot-list reference model.
module tb_tile_order_reader;

  localparam int N  = 24;
  localparam int IW = 6;
  localparam int PW = 5;
  localparam int OW = N * IW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  tile_order_reader_if #(.N_TILES(N), .ID_W(IW), .POS_W(PW)) bus ();

  tile_order_reader #(.N_TILES(N), .ID_W(IW), .POS_W(PW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int ord [N];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // {busy, error, tile_valid, done}
  function automatic logic [3:0] stat();
    return {bus.busy, bus.error, bus.tile_valid, bus.done};
  endfunction

  function automatic logic [OW-1:0] pack_ord();
    logic [OW-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[(N-1-k)*IW +: IW] = IW'(ord[k]);
    return p;
  endfunction

  // Index of the first slot whose id is out of range or repeated, -1 if none.
  function automatic int first_bad();
    bit seen [N];
    for (int k = 0; k < N; k++) seen[k] = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ord[k] >= N || seen[ord[k]]) return k;
      seen[ord[k]] = 1'b1;
    end
    return -1;
  endfunction

  task automatic set_identity();
    for (int k = 0; k < N; k++) ord[k] = k;
  endtask

  task automatic shuffle();
    int j, t;
    set_identity();
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
  endtask

  task automatic run_order(input string nm, input int rdy_pct, input bit poke, input int rst_pos);
    logic [OW-1:0] p;
    int  bad, exp_pos;
    bit  finished, rdy;
    p        = pack_ord();
    bad      = first_bad();
    exp_pos  = 0;
    finished = 1'b0;
    bus.order_in = p;
    bus.load     = 1'b1;
    @(posedge clk); #1;
    bus.load     = 1'b0;
    bus.order_in = ~p;
    for (int c = 1; c <= 10 * N && !finished; c++) begin
      @(posedge clk); #1;
      bus.load = 1'b0;
      if (bad >= 0) begin
        if (c <= bad) chk_eq({nm, " check"}, 32'(stat()), 32'(4'b1000));
        else begin
          chk_eq({nm, " reject"}, 32'(stat()), 32'(4'b0100));
          finished = 1'b1;
        end
      end else if (c < N) begin
        chk_eq({nm, " check"}, 32'(stat()), 32'(4'b1000));
        if (poke && c == 5) bus.load = 1'b1;
      end else if (exp_pos < N) begin
        chk_eq({nm, " stream"}, 32'(stat()), 32'(4'b1010));
        chk_eq({nm, " pos"},  32'(bus.tile_pos),  32'(exp_pos));
        chk_eq({nm, " id"},   32'(bus.tile_id),   32'(ord[exp_pos]));
        chk_eq({nm, " last"}, 32'(bus.tile_last), 32'(exp_pos == N - 1));
        if (exp_pos == rst_pos) begin
          rst_n = 1'b0;
          #1;
          chk_eq({nm, " rst stat"}, 32'(stat()), 32'(4'b0000));
          chk_eq({nm, " rst fields"},
                 32'({bus.tile_pos, bus.tile_id, bus.tile_last}), 32'(0));
          finished = 1'b1;
        end else begin
          if (poke && exp_pos == 10) bus.load = 1'b1;
          rdy = ($urandom_range(99, 0) < rdy_pct);
          bus.tile_ready = rdy;
          if (rdy) exp_pos++;
        end
      end else begin
        chk_eq({nm, " done"}, 32'(stat()), 32'(4'b0001));
        finished = 1'b1;
      end
    end
    bus.load = 1'b0;
    if (!finished) chk_eq({nm, " timeout"}, 32'(0), 32'(1));
    else if (rst_pos < 0) begin
      @(posedge clk); #1;
      chk_eq({nm, " settle"}, 32'(stat()), (bad >= 0) ? 32'(4'b0100) : 32'(4'b0000));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.load       = 1'b0;
    bus.order_in   = '0;
    bus.tile_ready = 1'b0;
    #1 rst_n = 1'b0;
    #12;
    chk_eq("reset stat", 32'(stat()), 32'(4'b0000));
    chk_eq("reset fields", 32'({bus.tile_pos, bus.tile_id, bus.tile_last}), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("idle stat", 32'(stat()), 32'(4'b0000));

    set_identity();
    run_order("ident", 100, 1'b0, -1);

    for (int k = 0; k < N; k++) ord[k] = N - 1 - k;
    run_order("rev", 50, 1'b0, -1);

    set_identity(); ord[2] = 7; ord[5] = 7;
    run_order("dup", 100, 1'b0, -1);
    set_identity();
    run_order("ident2", 100, 1'b0, -1);

    set_identity(); ord[23] = 24;
    run_order("oor23", 100, 1'b0, -1);
    set_identity(); ord[0] = 63;
    run_order("oor0", 100, 1'b0, -1);

    shuffle();
    run_order("poke", 70, 1'b1, -1);

    for (int r = 0; r < 6; r++) begin
      shuffle();
      if (r % 2 == 1) ord[$urandom_range(N - 1, 0)] = $urandom_range(63, 0);
      run_order($sformatf("rnd%0d", r), $urandom_range(90, 30), 1'b0, -1);
    end

    set_identity();
    run_order("rstmid", 100, 1'b0, 12);
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst hold", 32'(stat()), 32'(4'b0000));
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("rst release", 32'(stat()), 32'(4'b0000));
    shuffle();
    run_order("after_rst", 80, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
